dac_sample_sched: RTL

DAC_SAMPLE_SCHED -- requirements
Module: dac_sample_sched

---
 rtl/dac_sample_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dac_sample_sched.sv
`default_nettype none
// ============================================================================
// dac_sample_sched : paced DAC sample player with 4-deep FIFO, sticky
// underrun flag and optional ramp-to-midscale on stop (macro DAC_SCHED_RAMP_EN).
// Revision: 1.0
// ============================================================================
module dac_sample_sched #(
    parameter int MSBI  = 7,
    parameter int DIV_W = 16
) (
    input  logic             CLK_i,
    input  logic             RSTn_i,
    input  logic             EN_i,
    input  logic [DIV_W-1:0] DIV_i,
    input  logic [MSBI:0]    S_DATA_i,
    input  logic             S_VALID_i,
    output logic             S_READY_o,
    output logic [MSBI:0]    DAC_CODE_o,
    output logic             SAMPLE_STB_o,
    output logic             UNDERRUN_o,
    input  logic             CLR_UNDERRUN_i,
    output logic [2:0]       LEVEL_o,
    output logic [1:0]       STATE_o
);

    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_RUN   = 2'd1;
    localparam logic [1:0]       ST_RAMP  = 2'd2;
    localparam logic [MSBI:0]    MIDSCALE = {1'b1, {MSBI{1'b0}}};
    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [MSBI:0]    fifo [4];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [2:0]       level;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] cnt;
    logic             ready;
    logic             tick;
    logic             push;
    logic             pop;
    logic             run_en;
    logic             stop;

    assign run_en = (state == ST_RUN) && EN_i;
    assign stop   = (state == ST_RUN) && !EN_i;
    assign tick   = ((state == ST_RUN) || (state == ST_RAMP)) && (cnt == div_lat);
    // The pop looks only at the pre-edge level, so a same-cycle push is never popped.
    assign pop    = run_en && tick && (level != 3'd0);
    assign push   = S_VALID_i && ready;

`ifdef DAC_SCHED_RAMP_EN
    logic [MSBI:0] ramp_code;
    localparam logic [MSBI:0] CODE_ONE = {{MSBI{1'b0}}, 1'b1};

    always_comb begin
        ramp_code = DAC_CODE_o;
        if (DAC_CODE_o > MIDSCALE) begin
            ramp_code = DAC_CODE_o - CODE_ONE;
        end else if (DAC_CODE_o < MIDSCALE) begin
            ramp_code = DAC_CODE_o + CODE_ONE;
        end
    end
`endif

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (EN_i) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!EN_i) begin
`ifdef DAC_SCHED_RAMP_EN
                    state_nxt = ST_RAMP;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            ST_RAMP: begin
`ifdef DAC_SCHED_RAMP_EN
                if (tick && (ramp_code == MIDSCALE)) begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state != ST_RAMP) && (level < 3'd4);
        S_READY_o = ready;
        STATE_o   = state;
        LEVEL_o   = level;
    end

    always_ff @(posedge CLK_i) begin
        if (push) begin
            fifo[wr_ptr] <= S_DATA_i;
        end
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            div_lat      <= '0;
            cnt          <= '0;
            rd_ptr       <= 2'd0;
            wr_ptr       <= 2'd0;
            level        <= 3'd0;
            DAC_CODE_o   <= MIDSCALE;
            SAMPLE_STB_o <= 1'b0;
            UNDERRUN_o   <= 1'b0;
        end else begin
            SAMPLE_STB_o <= pop;

            // Rate counter free-runs in RUN/RAMP and restarts on every state change.
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (EN_i) begin
                    div_lat <= DIV_i;
                end
            end else if (stop || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            if (stop) begin
                rd_ptr <= 2'd0;
                wr_ptr <= 2'd0;
                level  <= 3'd0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                end
                if (push && !pop) begin
                    level <= level + 3'd1;
                end else if (pop && !push) begin
                    level <= level - 3'd1;
                end
            end

            if (pop) begin
                DAC_CODE_o <= fifo[rd_ptr];
`ifdef DAC_SCHED_RAMP_EN
            end else if ((state == ST_RAMP) && tick) begin
                DAC_CODE_o <= ramp_code;
`else
            end else if (stop) begin
                DAC_CODE_o <= MIDSCALE;
`endif
            end

            if (run_en && tick && (level == 3'd0)) begin
                UNDERRUN_o <= 1'b1;
            end else if (CLR_UNDERRUN_i) begin
                UNDERRUN_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
